uart_top: RTL and testbench

// - Board-level UART demo top: 8N1 receiver (uart_rx) plus transmitter (uart_tx) plus hex display.
// - Each byte received on i_Rx is latched and shown on two 7-seg digits (high and low nibble).
// - Pressing push-button k (active-low) transmits one fixed byte on o_Tx.

---
 rtl/uart_top.sv | 158 +++++++++++++++
 tb/tb_uart_top.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// uart_top: 8N1 UART receiver with hex display latch and push-button byte transmitter.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_fTx,
  input  logic [7:0] i_Data,
  output logic       o_fDone,
  output logic       o_fReady,
  output logic       o_Tx
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] data;
  logic tick;
  assign tick = cnt == LAST;
  assign o_fReady = state == IDLE;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      o_Tx <= 1'b1;
      o_fDone <= 1'b0;
    end else begin
      o_fDone <= 1'b0;
      cnt <= (state == IDLE || tick) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (i_fTx) begin
          data <= i_Data;
          o_Tx <= 1'b0;
          state <= START;
        end
        START: if (tick) begin
          o_Tx <= data[0];
          data <= data >> 1;
          idx <= '0;
          state <= DATA;
        end
        DATA: if (tick) begin
          o_Tx <= idx == 3'd7 ? 1'b1 : data[0];
          data <= data >> 1;
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end
        default: if (tick) begin
          o_fDone <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Rx,
  output logic       o_fDone,
  output logic [7:0] o_Data
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic s1, s2, s3, err, tick, half;
  assign tick = cnt == LAST;
  assign half = cnt == HALF;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      {s1, s2, s3} <= 3'b111;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      err <= 1'b0;
      o_Data <= '0;
      o_fDone <= 1'b0;
    end else begin
      {s1, s2, s3} <= {i_Rx, s1, s2};
      o_fDone <= 1'b0;
      cnt <= (state == IDLE || (state == START ? half : tick)) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (s3 && !s2) state <= START;
        START: if (half) begin
          idx <= '0;
          state <= s2 ? IDLE : DATA;
        end
        DATA: if (tick) begin
          shift <= {s2, shift[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end
        default: if (tick) begin
          // a low stop bit waits out one more bit time before rearming
          if (err) begin
            err <= 1'b0;
            state <= IDLE;
          end else if (s2) begin
            o_Data <= shift;
            o_fDone <= 1'b1;
            state <= IDLE;
          end else err <= 1'b1;
        end
      endcase
    end
endmodule

module uart_top #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       i_Rx,
  input  logic [3:0] i_Push,
  output logic       o_Tx,
  output logic [6:0] o_FND_H,
  output logic [6:0] o_FND_L
);
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic rx_done, tx_done, tx_ready, tx_start;
  logic [7:0] rx_data, tx_byte, latched;
  logic [3:0] p1, p2, p3, press;
  assign press = p3 & ~p2;
  assign tx_byte = press[0] ? 8'h30 : press[1] ? 8'h31 : press[2] ? 8'h32 : 8'h33;
  assign tx_start = |press && tx_ready && !tx_done;
  assign o_FND_H = SEG[latched[7:4]];
  assign o_FND_L = SEG[latched[3:0]];
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      {p1, p2, p3} <= '1;
      latched <= '0;
    end else begin
      {p1, p2, p3} <= {i_Push, p1, p2};
      if (rx_done) latched <= rx_data;
    end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .Clk(Clk), .Rst(Rst), .i_Rx(i_Rx), .o_fDone(rx_done), .o_Data(rx_data)
  );
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .Clk(Clk), .Rst(Rst), .i_fTx(tx_start), .i_Data(tx_byte),
    .o_fDone(tx_done), .o_fReady(tx_ready), .o_Tx(o_Tx)
  );
endmodule

// File: tb/tb_uart_top.sv
// tb_uart_top: scoreboard bench for uart_top, bench serial driver on i_Rx and monitor on o_Tx.
module tb_uart_top;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [3:0] push = 4'hF;
  logic tx;
  logic [6:0] fnd_h, fnd_l;
  int n_cmp = 0, n_err = 0, tx_frames = 0;
  logic rst_seen = 1'b0;
  logic [7:0] exp_tx[$];
  logic [13:0] exp_disp[$];

  uart_top #(.CLKS_PER_BIT(CPB)) dut (
    .Clk(clk), .Rst(rst_n), .i_Rx(rx), .i_Push(push),
    .o_Tx(tx), .o_FND_H(fnd_h), .o_FND_L(fnd_l)
  );

  always #10 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic press_one(input logic [3:0] pat, input logic [7:0] b);
    exp_tx.push_back(b);
    push = pat;
    for (int i = 0; i < 600 && exp_tx.size() != 0; i++) @(negedge clk);
    check("tx_drain", exp_tx.size(), 0);
    push = 4'hF;
    repeat (200) @(negedge clk);
  endtask

  // serial monitor on o_Tx: sample each bit at mid-bit
  initial forever begin
    logic [7:0] b;
    logic st, sp;
    @(negedge clk);
    if (rst_n && !tx) begin
      rst_seen = 1'b0;
      repeat (CPB / 2 - 1) @(negedge clk);
      st = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      sp = tx;
      if (!rst_seen) begin
        tx_frames++;
        check("tx_start_bit", 32'(st), 0);
        check("tx_stop_bit", 32'(sp), 1);
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected: got %0h expected none", b);
        end else check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
      end
    end
  end

  // display monitor: compare the latched glyphs one cycle after each receive
  initial forever begin
    logic [13:0] e;
    @(negedge clk);
    if (dut.rx_done) begin
      @(negedge clk);
      if (exp_disp.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL disp_unexpected: got %0h/%0h expected none", fnd_h, fnd_l);
      end else begin
        e = exp_disp.pop_front();
        check("fnd_h", 32'(fnd_h), 32'(e[13:7]));
        check("fnd_l", 32'(fnd_l), 32'(e[6:0]));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_fnd_h", 32'(fnd_h), 32'h40);
    check("rst_fnd_l", 32'(fnd_l), 32'h40);
    check("rst_no_frames", tx_frames, 0);
    exp_disp.push_back({7'b0110000, 7'b1000110});
    send_rx(8'h3C, 1'b1);
    check("disp_drain_3c", exp_disp.size(), 0);
    exp_disp.push_back({7'b0000110, 7'b0010010});
    send_rx(8'hE5, 1'b1);
    check("disp_drain_e5", exp_disp.size(), 0);
    press_one(4'b1110, 8'h30);
    press_one(4'b1101, 8'h31);
    press_one(4'b1011, 8'h32);
    press_one(4'b0111, 8'h33);
    press_one(4'b1100, 8'h30);
    check("tx_idle_high", 32'(tx), 1);
    check("tx_frame_count", tx_frames, 5);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_fnd_h", 32'(fnd_h), 32'h06);
    check("glitch_fnd_l", 32'(fnd_l), 32'h12);
    send_rx(8'hA7, 1'b0);
    check("frame_err_fnd_h", 32'(fnd_h), 32'h06);
    check("frame_err_fnd_l", 32'(fnd_l), 32'h12);
    push = 4'b1101;
    repeat (80) @(negedge clk);
    rst_seen = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort_tx_high", 32'(tx), 1);
    push = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("abort_fnd_h", 32'(fnd_h), 32'h40);
    check("abort_fnd_l", 32'(fnd_l), 32'h40);
    press_one(4'b1011, 8'h32);
    check("final_frame_count", tx_frames, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
